lsu: RTL and testbench
======================

# lsu

Load/store unit between the single-cycle MIPS datapath and the data-memory bus. It consumes the datapath's ALU result (address) and store data, and drives a req/ack memory bus with byte enables. It returns the aligned, extended load word as `readdata` and stalls the core until the access completes. It also flags misaligned accesses and (optionally) bus timeouts.

## Interface
- `TIMEOUT_CYCLES`, default 255: max cycles `mem_req` waits for `mem_ack` (used only with `LSU_TIMEOUT_EN`).
- `clk` in 1: core clock, all state on rising edge.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `memread` in 1: core requests a load this instruction.
- `memwrite` in 1: core requests a store; wins if both are asserted.
- `size` in 2: access size, 0=byte, 1=half, 2=word; 3 is treated as word.
- `ld_unsigned` in 1: zero-extend a byte/half load (else sign-extend).
- `addr` in 32: byte address (datapath `aluout`).
- `wdata` in 32: store data (datapath `writedata`), right-justified.
- `readdata` out 32: registered load result to the datapath.
- `stall` out 1: hold PC/regfile write while the access is in flight.
- `err` out 1: misaligned or timed-out access, valid in the completing cycle.
- `mem_req` out 1: bus request, registered.
- `mem_we` out 1: bus write.
- `mem_addr` out 32: word address, `{addr[31:2],2'b00}`, registered.
- `mem_be` out 4: byte enables, registered.
- `mem_wdata` out 32: lane-replicated store data, registered.
- `mem_ack` in 1: single-cycle completion pulse from memory.
- `mem_rdata` in 32: read word, valid with `mem_ack`.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If `memread|memwrite` and aligned: latch the bus fields, go to REQ.
  - If misaligned (half with `addr[0]`=1, or word with `addr[1:0]`≠0): no bus access, set `err`, go to DONE.
- REQ: `mem_req`=1 with stable fields until `mem_ack`.
  - On ack: a load latches the extracted, extended data into `readdata`; a store leaves `readdata` unchanged. Go to DONE.
- DONE: `stall`=0 and the core retires at the next edge. `err` is held for this cycle only. Go to IDLE.
- `stall` = (IDLE & (`memread|memwrite`)) | REQ. It is combinational and 0 in DONE.
- Lanes are little-endian; `n`=`addr[1:0]`.
  - Byte: `be`=1<<n; `wdata` replicated `{4{wdata[7:0]}}`; load takes byte n.
  - Half: `be`=`4'b0011`<<n; `wdata` replicated `{2{wdata[15:0]}}`; load takes half `n[1]`.
  - Word: `be`=`4'hF`.
- `mem_ack` outside REQ is ignored, including late acks.
- A misaligned load writes 0 to `readdata`.

## Timing
- Reset values: state IDLE, `mem_req`/`mem_we`/`err`=0, `mem_addr`/`mem_be`/`mem_wdata`/`readdata`=0.
- Reset mid-access: `mem_req` drops asynchronously and the access is abandoned. The memory must tolerate a withdrawn request.
- Aligned access with a zero-wait memory (ack in the first REQ cycle): 3 cycles total, `stall` high for 2. Each memory wait cycle adds one.
- Misaligned access: 2 cycles, `stall` high for 1.
- `readdata` is valid from the DONE cycle until the next load completes.

## Configuration
- `LSU_TIMEOUT_EN` defined: an 8..32-bit counter (sized from `TIMEOUT_CYCLES`) runs in REQ.
  - When the counter reaches `TIMEOUT_CYCLES` with no ack: drop `mem_req`, set `err`, go to DONE, and force `readdata`=0 for a load.
  - The counter clears on entering REQ.
- `LSU_TIMEOUT_EN` undefined: no counter; REQ waits indefinitely; `err` reports only misalignment.

## Structure
- `lsu_pkg` holds:
  - the size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - the `lsu_state_t` enum {IDLE, REQ, DONE};
  - the default timeout constant.
- One combinational sub-module, `lsu_lane`, does:
  - byte-enable generation, store replication and the misalignment check from `size`/`addr[1:0]`;
  - load extraction and extension from `mem_rdata`, `size`, `addr[1:0]` and `ld_unsigned`.
- The `lsu` top holds the FSM, the bus registers and the timeout counter.

## Test plan
- Word store to `addr`=0x100 with `wdata`=0xDEADBEEF and ack on the first REQ cycle → `mem_addr`=0x100, `be`=F, `mem_wdata`=0xDEADBEEF; `stall` 2 cycles; `err`=0.
- Byte load at 0x103 with `mem_rdata`=0x80FF1234 → signed gives `readdata`=0xFFFFFF80; `ld_unsigned` gives 0x00000080; `be`=8.
- Half store at 0x202 with `wdata`=0x0000ABCD → `be`=C, `mem_wdata`=0xABCDABCD. Half load at the same address with `mem_rdata`=0x7FFE0000 → `readdata`=0x00007FFE.
- Word load at 0x101 → no `mem_req`, `err`=1 in DONE, `stall` 1 cycle, `readdata`=0.
- Ack delayed 5 cycles, then `reset_n` pulsed during a second access → the first completes with `stall` 7 cycles; on reset, `mem_req` drops immediately, state is IDLE and all outputs are 0.
- With `LSU_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4: no ack → `mem_req` drops after 4 REQ cycles and `err`=1; a later stray `mem_ack` is ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the default bus timeout.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int LSU_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Counter width able to hold n, kept within 8..32 bits.
  function automatic int lsu_cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    if (w < 8)  w = 8;
    if (w > 32) w = 32;
    return w;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane logic: byte enables, store replication, misalignment check and
// load extraction/extension. Purely combinational. Size 3 behaves as word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        ld_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  output logic [31:0] ldata
);

  logic [7:0]  b;
  logic [15:0] h;

  // Little-endian lane selection for the given size and offset
  always_comb begin
    b         = rdata[{off, 3'b000} +: 8];
    h         = off[1] ? rdata[31:16] : rdata[15:0];
    be        = 4'hF;
    wdata_rep = wdata;
    misalign  = (off != 2'b00);
    ldata     = rdata;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        misalign  = 1'b0;
        ldata     = {{24{~ld_unsigned & b[7]}}, b};
      end
      SZ_HALF: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = off[0];
        ldata     = {{16{~ld_unsigned & h[15]}}, h};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: turns datapath load/store requests into a registered
// req/ack bus access and stalls the core until it completes.
// Optional feature macro: LSU_TIMEOUT_EN (bus timeout counter in REQ).
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  lsu_state_t state, nstate;

  logic        acc;
  logic        to_hit;
  logic [1:0]  r_size, r_off;
  logic        r_uns;
  logic [1:0]  l_size, l_off;
  logic        l_uns;
  logic [3:0]  be;
  logic [31:0] wdata_rep, ldata;
  logic        misalign;

  assign acc = memread | memwrite;

  // Lane logic sees live inputs while idle and the latched access afterwards,
  // so extraction does not depend on the core holding addr/size stable.
  assign l_size = (state == IDLE) ? size           : r_size;
  assign l_off  = (state == IDLE) ? addr[1:0]      : r_off;
  assign l_uns  = (state == IDLE) ? ld_unsigned    : r_uns;

  lsu_lane u_lane (
    .size        (l_size),
    .off         (l_off),
    .ld_unsigned (l_uns),
    .wdata       (wdata),
    .rdata       (mem_rdata),
    .be          (be),
    .wdata_rep   (wdata_rep),
    .misalign    (misalign),
    .ldata       (ldata)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CW = lsu_cnt_w(TIMEOUT_CYCLES);
  logic [CW-1:0] to_cnt;

  // Count REQ cycles; held at zero outside REQ so it is clear on entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          to_cnt <= '0;
    else if (state != REQ) to_cnt <= '0;
    else                   to_cnt <= to_cnt + 1'b1;
  end

  // Fires in the last permitted REQ cycle when no ack has arrived
  assign to_hit = (state == REQ) && !mem_ack &&
                  (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nstate;
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (acc) nstate = misalign ? DONE : REQ;
      REQ:     if (mem_ack || to_hit) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Stall covers the request cycle and every bus cycle, never DONE
  always_comb begin
    stall = ((state == IDLE) && acc) || (state == REQ);
  end

  // Bus fields, latched access attributes, error and load result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      readdata  <= '0;
      err       <= 1'b0;
      r_size    <= '0;
      r_off     <= '0;
      r_uns     <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          if (misalign) begin
            err <= 1'b1;
            if (!memwrite) readdata <= '0;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= memwrite;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= be;
            mem_wdata <= wdata_rep;
            r_size    <= size;
            r_off     <= addr[1:0];
            r_uns     <= ld_unsigned;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) readdata <= ldata;
          end else if (to_hit) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            if (!mem_we) readdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus random accesses checked
// against an arithmetic lane model and a simple responding memory.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        memread, memwrite, ld_unsigned;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] readdata;
  logic        stall, err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;
  logic [31:0] rd_model = '0;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .memread     (memread),
    .memwrite    (memwrite),
    .size        (size),
    .ld_unsigned (ld_unsigned),
    .addr        (addr),
    .wdata       (wdata),
    .readdata    (readdata),
    .stall       (stall),
    .err         (err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: number of bytes in an access
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    int v = ((1 << n) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wrep(input logic [1:0] sz, input logic [31:0] wd);
    if (nbytes(sz) == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
    if (nbytes(sz) == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                          input bit uns, input logic [31:0] rd);
    int n = nbytes(sz);
    logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
    logic [63:0] v    = ({32'd0, rd} >> (8 * (a % 4))) & mask;
    if (!uns && n < 4 && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // One core access; dly<0 means the memory never acks.
  task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat, input int dly, input string nm);
    int  n = 0, waits = 0, reqc = 0;
    bit  seen = 0;
    bit  mis = m_mis(sz, a);
    bit  ld  = !wr;
    int  exp_n;
    memread = rd; memwrite = wr; size = sz; ld_unsigned = uns;
    addr = a; wdata = wd; mem_ack = 1'b0; mem_rdata = $urandom;
    #1;
    while (stall === 1'b1 && n < 64) begin
      n++;
      if (mem_req === 1'b1) begin
        reqc++;
        if (!seen) begin
          seen = 1;
          chk({nm, ".addr"}, mem_addr, {a[31:2], 2'b00});
          chk({nm, ".be"},   {28'd0, mem_be}, {28'd0, m_be(sz, a)});
          chk({nm, ".we"},   {31'd0, mem_we}, {31'd0, wr});
          if (wr) chk({nm, ".wdata"}, mem_wdata, m_wrep(sz, wd));
        end
        if (dly >= 0 && waits == dly) begin mem_ack = 1'b1; mem_rdata = rdat; end
        else begin mem_ack = 1'b0; mem_rdata = $urandom; end
        waits++;
      end else mem_ack = 1'b0;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    exp_n = mis ? 1 : (dly < 0) ? 5 : 2 + dly;
    chk({nm, ".stall"}, n, exp_n);
    chk({nm, ".err"}, {31'd0, err}, {31'd0, (mis || dly < 0)});
    chk({nm, ".seen"}, {31'd0, seen}, {31'd0, !mis});
    if (dly < 0 && !mis) chk({nm, ".reqcyc"}, reqc, 4);
    if (ld) rd_model = (mis || dly < 0) ? 32'd0 : m_load(sz, a, uns, rdat);
    chk({nm, ".rdata"}, readdata, rd_model);
    memread = 1'b0; memwrite = 1'b0;
    @(negedge clk);
    chk({nm, ".idle_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; memread = 0; memwrite = 0; size = 0; ld_unsigned = 0;
    addr = 0; wdata = 0; mem_ack = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst.req",   {31'd0, mem_req}, 32'd0);
    chk("rst.bus",   {mem_be, mem_we, err, stall}, 32'd0);
    chk("rst.addr",  mem_addr, 32'd0);
    chk("rst.wdata", mem_wdata, 32'd0);
    chk("rst.rdata", readdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    access(0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, "sw");
    access(1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80FF1234, 0, "lb");
    access(1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80FF1234, 1, "lbu");
    access(0, 1, 2'd1, 0, 32'h202, 32'h0000ABCD, 32'h0, 0, "sh");
    access(1, 0, 2'd1, 0, 32'h202, 32'h0, 32'h7FFE0000, 2, "lh");
    access(1, 0, 2'd2, 0, 32'h101, 32'h0, 32'h12345678, 0, "lw_mis");
    access(1, 1, 2'd3, 0, 32'h104, 32'h0BADF00D, 32'h0, 0, "both");
    access(1, 0, 2'd2, 0, 32'h108, 32'h0, 32'hCAFEF00D, 5, "lw_slow");

    // Reset in the middle of a pending access
    memread = 1; memwrite = 0; size = 2'd2; addr = 32'h300; #1;
    repeat (3) @(negedge clk);
    chk("mid.req_up", {31'd0, mem_req}, 32'd1);
    memread = 0; reset_n = 1'b0; #1;
    chk("mid.req",   {31'd0, mem_req}, 32'd0);
    chk("mid.bus",   {mem_be, mem_we, err, stall}, 32'd0);
    chk("mid.addr",  mem_addr, 32'd0);
    chk("mid.rdata", readdata, 32'd0);
    rd_model = 32'd0;
    @(negedge clk); reset_n = 1'b1; @(negedge clk);

    // Stray ack while idle must not start anything
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk); mem_ack = 1'b0;
    chk("stray.req",   {31'd0, mem_req}, 32'd0);
    chk("stray.stall", {31'd0, stall}, 32'd0);
    chk("stray.rdata", readdata, rd_model);
    @(negedge clk);

`ifdef LSU_TIMEOUT_EN
    access(1, 0, 2'd2, 0, 32'h400, 32'h0, 32'h0, -1, "to_ld");
    mem_ack = 1'b1; @(negedge clk); mem_ack = 1'b0;
    chk("to.stray", {31'd0, mem_req}, 32'd0);
    access(0, 1, 2'd0, 0, 32'h401, 32'h55, 32'h0, -1, "to_sb");
`endif

    for (int i = 0; i < 40; i++) begin
      bit wr = $urandom_range(0, 1);
      bit rd = wr ? bit'($urandom_range(0, 1)) : 1'b1;
      access(rd, wr, 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, $urandom_range(0, 3), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
